// File: rtl/ddr5_cmd_sched_if.sv
// Request / command bundle between a requester and the DDR5 command scheduler.
// The scheduler uses the slave modport; the requester side uses master.
interface ddr5_cmd_sched_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_bg;
  logic        req_ba;
  logic [15:0] req_row;
  logic [9:0]  req_col;
  logic        req_done;
  logic [3:0]  cmd_state;
  logic        cmd_cs;
  logic [2:0]  cmd_bg;
  logic        cmd_ba;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        busy;

  modport master (
    output req_valid, req_write, req_bg, req_ba, req_row, req_col,
    input  req_ready, req_done, cmd_state, cmd_cs, cmd_bg, cmd_ba,
           cmd_row, cmd_col, busy
  );

  modport slave (
    input  req_valid, req_write, req_bg, req_ba, req_row, req_col,
    output req_ready, req_done, cmd_state, cmd_cs, cmd_bg, cmd_ba,
           cmd_row, cmd_col, busy
  );
endinterface

// File: rtl/ddr5_cmd_sched.sv
// DDR5 per-request command scheduler: accepts one access, then issues a
// two-cycle ACT followed by a two-cycle RDA/WRA toward the CA packet generator.
// tRCD is timed inside the request; tRC is enforced by 16 per-bank timers.
// Every output comes from a register loaded from the next-state decode, so the
// outputs line up exactly with the FSM state they describe.
module ddr5_cmd_sched #(
  parameter int T_RCD = 8,
  parameter int T_RC  = 24,
  parameter int CNT_W = 6
) (
  input logic              clk,
  input logic              rst,
  ddr5_cmd_sched_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_ACT1 = 3'd2;
  localparam logic [2:0] S_ACT2 = 3'd3;
  localparam logic [2:0] S_RCD  = 3'd4;
  localparam logic [2:0] S_CAS1 = 3'd5;
  localparam logic [2:0] S_CAS2 = 3'd6;

  // The timer is loaded on the ACT1 cycle, first seen one cycle later, and the
  // WAIT_BANK exit decision precedes ACT1 by one cycle, hence T_RC-2.
  localparam logic [CNT_W-1:0] TRC_LOAD = CNT_W'(T_RC - 2);
  // RCD_WAIT lasts T_RCD-2 cycles; the counter runs down to zero inclusive.
  localparam logic [CNT_W-1:0] RCD_LOAD = (T_RCD > 2) ? CNT_W'(T_RCD - 3) : '0;
  localparam bit               RCD_SKIP = (T_RCD <= 2);

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [CNT_W-1:0] r_rcd_cnt;
  logic [CNT_W-1:0] r_timer [16];
  logic             r_write;
  logic [2:0]       r_bg;
  logic             r_ba;
  logic [15:0]      r_row;
  logic [9:0]       r_col;
  logic             r_ready;
  logic             r_done;
  logic             r_cs;
  logic             r_busy;
  logic [3:0]       r_cmd_state;
  logic [3:0]       w_bank;
  logic             w_bank_busy;
  logic             w_accept;

  // Command code seen by the packet generator for a given FSM state.
  function automatic logic [3:0] f_cmd_code(input logic [2:0] st, input logic wr);
    logic [3:0] code;
    case (st)
      S_ACT1, S_ACT2: code = 4'd8;
      S_CAS1, S_CAS2: code = wr ? 4'd5 : 4'd12;
      default:        code = 4'd0;
    endcase
    return code;
  endfunction

  assign w_bank      = {r_bg, r_ba};
  assign w_bank_busy = (r_timer[w_bank] != '0);
  assign w_accept    = (r_state == S_IDLE) && r_ready && bus.req_valid;

  // Next-state logic for the request sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_WAIT;
        else          w_next_state = S_IDLE;
      end
      S_WAIT: begin
        if (w_bank_busy) w_next_state = S_WAIT;
        else             w_next_state = S_ACT1;
      end
      S_ACT1: w_next_state = S_ACT2;
      S_ACT2: begin
        if (RCD_SKIP) w_next_state = S_CAS1;
        else          w_next_state = S_RCD;
      end
      S_RCD: begin
        if (r_rcd_cnt == '0) w_next_state = S_CAS1;
        else                 w_next_state = S_RCD;
      end
      S_CAS1:  w_next_state = S_CAS2;
      S_CAS2:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // tRCD countdown: loaded in ACT2, consumed during RCD_WAIT.
  always_ff @(posedge clk) begin
    if (rst)                                    r_rcd_cnt <= '0;
    else if (r_state == S_ACT2)                 r_rcd_cnt <= RCD_LOAD;
    else if ((r_state == S_RCD) && (r_rcd_cnt != '0)) r_rcd_cnt <= r_rcd_cnt - CNT_W'(1);
    else                                        r_rcd_cnt <= r_rcd_cnt;
  end

  // Per-bank tRC timers: reload on ACT1 to the captured bank, else count to zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (rst)                                          r_timer[i] <= '0;
      else if ((r_state == S_ACT1) && (w_bank == 4'(i))) r_timer[i] <= TRC_LOAD;
      else if (r_timer[i] != '0)                        r_timer[i] <= r_timer[i] - CNT_W'(1);
      else                                              r_timer[i] <= r_timer[i];
    end
  end

  // Request capture; held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_bg    <= 3'd0;
      r_ba    <= 1'b0;
      r_row   <= 16'd0;
      r_col   <= 10'd0;
    end else if (w_accept) begin
      r_write <= bus.req_write;
      r_bg    <= bus.req_bg;
      r_ba    <= bus.req_ba;
      r_row   <= bus.req_row;
      r_col   <= bus.req_col;
    end else begin
      r_write <= r_write;
      r_bg    <= r_bg;
      r_ba    <= r_ba;
      r_row   <= r_row;
      r_col   <= r_col;
    end
  end

  // Registered status/command outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_cs        <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_state <= 4'd0;
    end else begin
      r_ready     <= (w_next_state == S_IDLE);
      r_done      <= (w_next_state == S_CAS2);
      r_cs        <= (w_next_state == S_ACT1) || (w_next_state == S_CAS1);
      r_busy      <= (w_next_state != S_IDLE);
      r_cmd_state <= f_cmd_code(w_next_state, r_write);
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.req_done  = r_done;
  assign bus.cmd_cs    = r_cs;
  assign bus.busy      = r_busy;
  assign bus.cmd_state = r_cmd_state;
  assign bus.cmd_bg    = r_bg;
  assign bus.cmd_ba    = r_ba;
  assign bus.cmd_row   = r_row;
  assign bus.cmd_col   = r_col;

endmodule

// File: tb/tb_ddr5_cmd_sched.sv
// Bench for ddr5_cmd_sched: two instances (default timing and T_RCD=2/T_RC=4)
// run directed request sequences against a schedule-level model that derives
// ACT/CAS cycles from accept time, tRCD and per-bank last-ACT times.
module tb_ddr5_cmd_sched;

  typedef struct {
    logic        wr;
    logic [2:0]  bg;
    logic        ba;
    logic [15:0] row;
    logic [9:0]  col;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr5_cmd_sched_if u_if0();
  ddr5_cmd_sched_if u_if1();

  ddr5_cmd_sched #(.T_RCD(8), .T_RC(24), .CNT_W(6)) u_dut0 (
    .clk(clk), .rst(rst), .bus(u_if0.slave)
  );
  ddr5_cmd_sched #(.T_RCD(2), .T_RC(4), .CNT_W(6)) u_dut1 (
    .clk(clk), .rst(rst), .bus(u_if1.slave)
  );

  int   vecs = 0;
  int   errs = 0;
  int   cyc  = 0;
  bit   rst_req = 1'b0;
  bit   m_rst_seen = 1'b1;
  bit   m_active [2];
  int   m_act [2];
  int   m_cas [2];
  int   m_end [2];
  req_t m_cap [2];
  int   m_last [2][16];
  req_t q0 [$];
  req_t q1 [$];

  logic [3:0]  lg_state [2][1024];
  logic        lg_cs    [2][1024];
  logic        lg_done  [2][1024];
  logic        lg_ready [2][1024];
  logic        lg_busy  [2][1024];
  logic [2:0]  lg_bg    [2][1024];
  logic [15:0] lg_row   [2][1024];

  function automatic int trcd(int k); return (k == 0) ? 8 : 2; endfunction
  function automatic int trc(int k);  return (k == 0) ? 24 : 4; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  function automatic req_t mk(logic wr, logic [2:0] bg, logic ba, logic [15:0] row, logic [9:0] col);
    req_t r;
    r.wr = wr; r.bg = bg; r.ba = ba; r.row = row; r.col = col;
    return r;
  endfunction

  task automatic chk(string nm, int k, logic [31:0] got, logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, required %0h", nm, k, cyc, got, exp);
    end
  endtask

  task automatic drv(int k, logic v, req_t r);
    if (k == 0) begin
      u_if0.req_valid = v; u_if0.req_write = r.wr; u_if0.req_bg = r.bg;
      u_if0.req_ba = r.ba; u_if0.req_row = r.row; u_if0.req_col = r.col;
    end else begin
      u_if1.req_valid = v; u_if1.req_write = r.wr; u_if1.req_bg = r.bg;
      u_if1.req_ba = r.ba; u_if1.req_row = r.row; u_if1.req_col = r.col;
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0;
      m_cap[k] = mk(1'b0, 3'd0, 1'b0, 16'd0, 10'd0);
      for (int b = 0; b < 16; b++) m_last[k][b] = -1000;
    end
  endtask

  // One clock cycle: compare both DUTs against the model, then drive inputs.
  task automatic step();
    logic [3:0]  g_st;
    logic        g_cs, g_done, g_ready, g_busy, g_ba;
    logic [2:0]  g_bg;
    logic [15:0] g_row;
    logic [9:0]  g_col;
    logic [3:0]  e_st;
    logic        e_cs, e_done, e_ready, e_busy, vld;
    req_t        hd, rnd;
    int          qn, bank;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        g_st = u_if0.cmd_state; g_cs = u_if0.cmd_cs; g_done = u_if0.req_done;
        g_ready = u_if0.req_ready; g_busy = u_if0.busy; g_bg = u_if0.cmd_bg;
        g_ba = u_if0.cmd_ba; g_row = u_if0.cmd_row; g_col = u_if0.cmd_col;
      end else begin
        g_st = u_if1.cmd_state; g_cs = u_if1.cmd_cs; g_done = u_if1.req_done;
        g_ready = u_if1.req_ready; g_busy = u_if1.busy; g_bg = u_if1.cmd_bg;
        g_ba = u_if1.cmd_ba; g_row = u_if1.cmd_row; g_col = u_if1.cmd_col;
      end
      if (m_active[k] && (cyc >= m_end[k])) m_active[k] = 1'b0;
      e_busy  = m_active[k];
      e_ready = !m_active[k] && !m_rst_seen;
      e_st = 4'd0;
      if (m_active[k] && ((cyc == m_act[k]) || (cyc == m_act[k] + 1))) e_st = 4'd8;
      else if (m_active[k] && ((cyc == m_cas[k]) || (cyc == m_cas[k] + 1)))
        e_st = m_cap[k].wr ? 4'd5 : 4'd12;
      e_cs   = m_active[k] && ((cyc == m_act[k]) || (cyc == m_cas[k]));
      e_done = m_active[k] && (cyc == m_cas[k] + 1);
      chk("cmd_state", k, 32'(g_st), 32'(e_st));
      chk("cmd_cs", k, 32'(g_cs), 32'(e_cs));
      chk("req_done", k, 32'(g_done), 32'(e_done));
      chk("req_ready", k, 32'(g_ready), 32'(e_ready));
      chk("busy", k, 32'(g_busy), 32'(e_busy));
      chk("cmd_addr", k, {g_bg, g_ba, g_row, g_col, 2'b00}, {m_cap[k].bg, m_cap[k].ba, m_cap[k].row, m_cap[k].col, 2'b00});
      if (cyc < 1024) begin
        lg_state[k][cyc] = g_st; lg_cs[k][cyc] = g_cs; lg_done[k][cyc] = g_done;
        lg_ready[k][cyc] = g_ready; lg_busy[k][cyc] = g_busy;
        lg_bg[k][cyc] = g_bg; lg_row[k][cyc] = g_row;
      end
      qn  = (k == 0) ? q0.size() : q1.size();
      vld = (qn > 0) && !rst_req;
      rnd = mk(1'($urandom), 3'($urandom), 1'($urandom), 16'($urandom), 10'($urandom));
      hd  = rnd;
      if (vld && e_ready) hd = (k == 0) ? q0[0] : q1[0];
      drv(k, vld, hd);
      if (vld && e_ready) begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        bank = {hd.bg, hd.ba};
        m_active[k] = 1'b1;
        m_act[k] = imax(cyc + 2, m_last[k][bank] + trc(k));
        m_last[k][bank] = m_act[k];
        m_cas[k] = m_act[k] + trcd(k);
        m_end[k] = m_cas[k] + 2;
        m_cap[k] = hd;
      end
    end
    rst = rst_req;
    if (rst_req) clear_model();
    m_rst_seen = rst_req;
    cyc++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push2(req_t r);
    q0.push_back(r);
    q1.push_back(r);
  endtask

  task automatic pin(string nm, int k, int at, logic [31:0] got, logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL pin %s dut%0d at cycle %0d: got %0h, required %0h", nm, k, at, got, exp);
    end
  endtask

  int b;

  initial begin
    clear_model();
    drv(0, 1'b0, mk(1'b0, 3'd0, 1'b0, 16'd0, 10'd0));
    drv(1, 1'b0, mk(1'b0, 3'd0, 1'b0, 16'd0, 10'd0));
    @(posedge clk);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;

    // Single read after reset: accepted in the first cycle req_ready is high.
    push2(mk(1'b0, 3'd3, 1'b1, 16'h1234, 10'h2A8));
    b = cyc + 1;
    run(16);
    pin("rst_ready_low", 0, b - 1, 32'(lg_ready[0][b-1]), 32'd0);
    pin("rd_act1", 0, b + 2, 32'(lg_state[0][b+2]), 32'd8);
    pin("rd_act2", 0, b + 3, 32'(lg_state[0][b+3]), 32'd8);
    pin("rd_gap_lo", 0, b + 4, 32'(lg_state[0][b+4]), 32'd0);
    pin("rd_gap_hi", 0, b + 9, 32'(lg_state[0][b+9]), 32'd0);
    pin("rd_cas1", 0, b + 10, 32'(lg_state[0][b+10]), 32'd12);
    pin("rd_cas2", 0, b + 11, 32'(lg_state[0][b+11]), 32'd12);
    pin("rd_cs_act", 0, b + 2, 32'(lg_cs[0][b+2]), 32'd1);
    pin("rd_cs_act2", 0, b + 3, 32'(lg_cs[0][b+3]), 32'd0);
    pin("rd_cs_cas", 0, b + 10, 32'(lg_cs[0][b+10]), 32'd1);
    pin("rd_done", 0, b + 11, 32'(lg_done[0][b+11]), 32'd1);
    pin("rd_ready_back", 0, b + 12, 32'(lg_ready[0][b+12]), 32'd1);
    pin("rd_busy_c1", 0, b + 1, 32'(lg_busy[0][b+1]), 32'd1);
    pin("rd_row", 0, b + 1, 32'(lg_row[0][b+1]), 32'h1234);
    pin("rcd2_cas1", 1, b + 4, 32'(lg_state[1][b+4]), 32'd12);
    pin("rcd2_done", 1, b + 5, 32'(lg_done[1][b+5]), 32'd1);
    pin("rcd2_ready", 1, b + 6, 32'(lg_ready[1][b+6]), 32'd1);

    // Write to the same bank once its tRC window has expired.
    run(12);
    b = cyc;
    push2(mk(1'b1, 3'd3, 1'b1, 16'h1234, 10'h2A8));
    run(14);
    pin("wr_act1", 0, b + 2, 32'(lg_state[0][b+2]), 32'd8);
    pin("wr_cas1", 0, b + 10, 32'(lg_state[0][b+10]), 32'd5);
    pin("wr_cas2", 0, b + 11, 32'(lg_state[0][b+11]), 32'd5);
    pin("wr_done", 0, b + 11, 32'(lg_done[0][b+11]), 32'd1);
    pin("wr_ready", 0, b + 12, 32'(lg_ready[0][b+12]), 32'd1);

    // Back-to-back reads to bank 0: second ACT1 held to first ACT1 + T_RC.
    b = cyc;
    push2(mk(1'b0, 3'd0, 1'b0, 16'h0001, 10'h001));
    push2(mk(1'b0, 3'd0, 1'b0, 16'h0002, 10'h002));
    run(40);
    pin("b2b_act_first", 0, b + 2, 32'(lg_state[0][b+2]), 32'd8);
    pin("b2b_accept2", 0, b + 12, 32'(lg_ready[0][b+12]), 32'd1);
    pin("b2b_wait_start", 0, b + 13, 32'({lg_busy[0][b+13], lg_state[0][b+13]}), 32'h10);
    pin("b2b_wait_end", 0, b + 25, 32'({lg_busy[0][b+25], lg_state[0][b+25]}), 32'h10);
    pin("b2b_act_second", 0, b + 26, 32'(lg_state[0][b+26]), 32'd8);
    pin("b2b_cs_second", 0, b + 26, 32'(lg_cs[0][b+26]), 32'd1);
    pin("b2b_model_last", 0, b + 26, 32'(m_last[0][0]), 32'(b + 26));
    pin("b2b_short_trc", 1, b + 8, 32'(lg_state[1][b+8]), 32'd8);

    // Different banks back to back: no tRC stall.
    run(30);
    b = cyc;
    push2(mk(1'b0, 3'd0, 1'b0, 16'h0A0A, 10'h010));
    push2(mk(1'b0, 3'd5, 1'b0, 16'h0B0B, 10'h020));
    run(30);
    pin("diff_accept2", 0, b + 12, 32'(lg_ready[0][b+12]), 32'd1);
    pin("diff_wait", 0, b + 13, 32'(lg_state[0][b+13]), 32'd0);
    pin("diff_act2", 0, b + 14, 32'(lg_state[0][b+14]), 32'd8);
    pin("diff_bg", 0, b + 14, 32'(lg_bg[0][b+14]), 32'd5);

    // A, B, A to banks 0, 1, 0: A's second ACT1 waits for T_RC.
    run(4);
    b = cyc;
    push2(mk(1'b0, 3'd0, 1'b0, 16'h1111, 10'h011));
    push2(mk(1'b0, 3'd0, 1'b1, 16'h2222, 10'h022));
    push2(mk(1'b0, 3'd0, 1'b0, 16'h3333, 10'h033));
    run(45);
    pin("aba_actA", 0, b + 2, 32'(lg_state[0][b+2]), 32'd8);
    pin("aba_actB", 0, b + 14, 32'(lg_state[0][b+14]), 32'd8);
    pin("aba_acceptA2", 0, b + 24, 32'(lg_ready[0][b+24]), 32'd1);
    pin("aba_hold", 0, b + 25, 32'(lg_state[0][b+25]), 32'd0);
    pin("aba_actA2", 0, b + 26, 32'(lg_state[0][b+26]), 32'd8);

    // Reset in RCD_WAIT aborts the command and clears the bank timers.
    run(4);
    b = cyc;
    push2(mk(1'b0, 3'd3, 1'b1, 16'h4321, 10'h155));
    run(6);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    push2(mk(1'b0, 3'd3, 1'b1, 16'hBEEF, 10'h0AA));
    step();
    run(16);
    pin("mid_rst_state", 0, b + 7, 32'(lg_state[0][b+7]), 32'd0);
    pin("mid_rst_ready", 0, b + 7, 32'(lg_ready[0][b+7]), 32'd0);
    pin("mid_rst_busy", 0, b + 7, 32'(lg_busy[0][b+7]), 32'd0);
    pin("mid_rst_row", 0, b + 7, 32'(lg_row[0][b+7]), 32'd0);
    pin("mid_rst_ready8", 0, b + 8, 32'(lg_ready[0][b+8]), 32'd1);
    pin("mid_rst_act", 0, b + 10, 32'(lg_state[0][b+10]), 32'd8);
    pin("mid_rst_row_new", 0, b + 10, 32'(lg_row[0][b+10]), 32'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
